switch_sequencer: RTL and testbench

- Round-robin scheduler that shares the 4-way path switch between 4 requesters.
- Picks a requester and issues a one-cycle switch_enb with the new switch_select.
- Checks the switch's lock_enb/done handshake against the short and long (11->00) lock windows.
- On a good handshake, grants the path to the requester until it releases; on a bad one, flags an error.

---
 rtl/switch_sequencer.sv | 149 ++++++++++++++
 tb/tb_switch_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_sequencer.sv
// Round-robin sequencer that shares a 4-way path switch between four requesters,
// drives the switch command and polices the lock_enb/done handshake timing.
module switch_sequencer #(
  parameter int unsigned SHORT_MAX = 2,
  parameter int unsigned LONG_MAX  = 10,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] req_i,
  input  logic       lock_enb_i,
  input  logic       done_i,
  output logic       switch_enb_o,
  output logic [1:0] switch_select_o,
  output logic [3:0] gnt_o,
  output logic       busy_o,
  output logic       timeout_err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StLock,
    StHold,
    StErr
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       nsel_q, nsel_d;
  logic [1:0]       last_q, last_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;

  logic [CNT_W-1:0] cnt_max;
  logic [1:0]       start;
  logic [7:0]       req_dbl;
  logic [3:0]       req_rot;
  logic [1:0]       off;
  logic [1:0]       pick;

  // Rotate requests so bit 0 is the requester just after the last owner.
  assign start   = last_q + 2'd1;
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[start +: 4];

  always_comb begin
    off = 2'd3;
    if (req_rot[0])      off = 2'd0;
    else if (req_rot[1]) off = 2'd1;
    else if (req_rot[2]) off = 2'd2;
  end

  assign pick    = start + off;
  assign cnt_max = long_q ? CNT_W'(LONG_MAX) : CNT_W'(SHORT_MAX);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    nsel_d  = nsel_q;
    last_d  = last_q;
    long_d  = long_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          nsel_d  = pick;
          sel_d   = pick;
          long_d  = (sel_q == 2'b11) && (pick == 2'b00);
          state_d = StIssue;
        end
      end
      StIssue: begin
        // The wrap-around transition ignores the handshake in the command cycle.
        if (long_q) begin
          state_d = StSettle;
        end else if (done_i) begin
          state_d = StErr;
        end else if (lock_enb_i) begin
          cnt_d   = CNT_W'(1);
          state_d = StLock;
        end else begin
          state_d = StErr;
        end
      end
      StSettle: begin
        if (lock_enb_i) begin
          cnt_d   = CNT_W'(1);
          state_d = StLock;
        end else begin
          state_d = StErr;
        end
      end
      StLock: begin
        if (done_i) begin
          gnt_d   = 4'b0001 << nsel_q;
          last_d  = nsel_q;
          state_d = StHold;
        end else if (lock_enb_i && (cnt_q < cnt_max)) begin
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        end else begin
          state_d = StErr;
        end
      end
      StHold: begin
        if (!req_i[nsel_q]) begin
          gnt_d   = 4'b0000;
          state_d = StIdle;
        end
      end
      StErr: begin
        // Failing requester drops to lowest priority for the next round.
        last_d  = nsel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      sel_q   <= 2'b00;
      nsel_q  <= 2'b00;
      last_q  <= 2'b00;
      long_q  <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      nsel_q  <= nsel_d;
      last_q  <= last_d;
      long_q  <= long_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign switch_enb_o    = (state_q == StIssue);
  assign switch_select_o = sel_q;
  assign gnt_o           = gnt_q;
  assign busy_o          = (state_q != StIdle);
  assign timeout_err_o   = (state_q == StErr);

endmodule

// File: tb/tb_switch_sequencer.sv
// Bench for switch_sequencer: a transaction-thread model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_switch_sequencer;

  localparam int SHORT_MAX = 2;
  localparam int LONG_MAX  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0;
  logic       lock = 1'b0;
  logic       done = 1'b0;
  logic       switch_enb_o;
  logic [1:0] switch_select_o;
  logic [3:0] gnt_o;
  logic       busy_o;
  logic       timeout_err_o;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  switch_sequencer dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_i          (req),
    .lock_enb_i     (lock),
    .done_i         (done),
    .switch_enb_o   (switch_enb_o),
    .switch_select_o(switch_select_o),
    .gnt_o          (gnt_o),
    .busy_o         (busy_o),
    .timeout_err_o  (timeout_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one thread walks each arbitration round ----------------
  logic [1:0] m_sel = 2'b0, m_last = 2'b0;
  logic       m_enb = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  logic [3:0] m_gnt = 4'b0;
  bit         abort;

  task automatic m_out(input logic enb, input logic bsy, input logic err, input logic [3:0] g);
    m_enb = enb; m_busy = bsy; m_err = err; m_gnt = g;
  endtask

  task automatic m_edge();
    @(posedge clk);
    if (reset) begin
      abort = 1'b1; m_sel = 2'b0; m_last = 2'b0; m_out(0, 0, 0, 4'b0);
    end
  endtask

  initial begin : model
    logic [1:0] pick, p;
    bit found, lng, good;
    int n, limit;
    forever begin
      abort = 1'b0;
      m_out(0, 0, 0, 4'b0);
      m_edge();
      if (abort || req == 4'b0) continue;
      found = 1'b0;
      pick  = 2'b0;
      for (int k = 1; k <= 4; k++) begin
        p = 2'(int'(m_last) + k);
        if (!found && req[p]) begin pick = p; found = 1'b1; end
      end
      lng   = (m_sel == 2'd3) && (pick == 2'd0);
      limit = lng ? LONG_MAX : SHORT_MAX;
      m_sel = pick;
      m_out(1, 1, 0, 4'b0);
      m_edge();
      if (abort) continue;
      if (lng) begin
        m_out(0, 1, 0, 4'b0);
        m_edge();
        if (abort) continue;
      end
      good = 1'b0;
      if (lng ? lock : (lock && !done)) begin
        n = 1;
        forever begin
          m_out(0, 1, 0, 4'b0);
          m_edge();
          if (abort) break;
          if (done) begin good = 1'b1; break; end
          if (!lock || n == limit) break;
          n++;
        end
        if (abort) continue;
      end
      m_last = pick;
      if (good) begin
        m_out(0, 1, 0, 4'b0001 << pick);
        forever begin
          m_edge();
          if (abort || !req[pick]) break;
        end
      end else begin
        m_out(0, 1, 1, 4'b0);
        m_edge();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_enb", switch_enb_o, m_enb);
      chk("m_sel", switch_select_o, m_sel);
      chk("m_gnt", gnt_o, m_gnt);
      chk("m_busy", busy_o, m_busy);
      chk("m_err", timeout_err_o, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle with req already set.
  task automatic xact(input bit lng, input int nlock, input bit give_done, input bit drop);
    cyc();
    if (drop) req = 4'b0;
    if (lng) cyc();
    for (int i = 0; i < nlock; i++) begin
      lock = 1'b1;
      cyc();
    end
    lock = 1'b0;
    if (give_done) begin
      done = 1'b1;
      cyc();
      done = 1'b0;
    end
  endtask

  task automatic hold_release(input logic [3:0] exp_g, input logic [3:0] after);
    @(negedge clk);
    chk("hold_gnt", gnt_o, exp_g);
    chk("hold_noerr", timeout_err_o, 1'b0);
    cyc();
    req = req & ~exp_g;
    cyc();
    req = after;
  endtask

  task automatic err_check(input string name, input logic [1:0] exp_sel);
    @(negedge clk);
    chk({name, "_err"}, timeout_err_o, 1'b1);
    chk({name, "_gnt"}, gnt_o, 4'b0);
    chk({name, "_sel"}, switch_select_o, exp_sel);
    cyc();
    @(negedge clk);
    chk({name, "_idle"}, busy_o, 1'b0);
    chk({name, "_errlow"}, timeout_err_o, 1'b0);
  endtask

  localparam logic [3:0] RrOrder [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin : stim
    repeat (2) cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_enb", switch_enb_o, 1'b0);
    chk("rst_sel", switch_select_o, 2'b00);
    chk("rst_gnt", gnt_o, 4'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", timeout_err_o, 1'b0);

    // Basic grant of requester 2.
    req = 4'b0100;
    cyc();
    lock = 1'b1;
    @(negedge clk);
    chk("t1_enb", switch_enb_o, 1'b1);
    chk("t1_sel", switch_select_o, 2'b10);
    chk("t1_busy", busy_o, 1'b1);
    cyc();
    cyc();
    lock = 1'b0; done = 1'b1;
    cyc();
    done = 1'b0;
    @(negedge clk);
    chk("t1_gnt", gnt_o, 4'b0100);
    chk("t1_enb_low", switch_enb_o, 1'b0);
    cyc();
    req = 4'b0;
    cyc();
    @(negedge clk);
    chk("t1_rel_gnt", gnt_o, 4'b0);
    chk("t1_rel_busy", busy_o, 1'b0);

    // Round-robin with all requesting; the 11->00 step takes the long path.
    reset = 1'b1; cyc(); reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      xact(k == 3, 1, 1, 0);
      hold_release(RrOrder[k], (k == 3) ? 4'b0 : 4'b1111);
    end

    // Long path: 10 lock cycles pass, 11 time out.
    req = 4'b1000; xact(0, 1, 1, 0); hold_release(4'b1000, 4'b0);
    req = 4'b0001; xact(1, 10, 1, 0); hold_release(4'b0001, 4'b0);
    req = 4'b1000; xact(0, 1, 1, 0); hold_release(4'b1000, 4'b0);
    req = 4'b0001; xact(1, 11, 0, 1); err_check("long_to", 2'b00);

    // Short path timeouts.
    req = 4'b0010; xact(0, 1, 1, 0); hold_release(4'b0010, 4'b0);
    req = 4'b0100; xact(0, 3, 0, 1); err_check("short_to", 2'b10);
    req = 4'b1000; xact(0, 0, 0, 1); cyc(); err_check("no_lock", 2'b11);

    // Early done.
    req = 4'b0001; xact(1, 0, 1, 1); err_check("early_long", 2'b00);
    req = 4'b0010; xact(0, 0, 1, 1); err_check("early_short", 2'b01);

    // Reset in the middle of a long lock with the counter at 5.
    req = 4'b1000; xact(0, 1, 1, 0); hold_release(4'b1000, 4'b0);
    req = 4'b0001;
    cyc();
    cyc();
    lock = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    chk("mid_busy", busy_o, 1'b1);
    reset = 1'b1; lock = 1'b0; req = 4'b0;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("ar_sel", switch_select_o, 2'b00);
    chk("ar_busy", busy_o, 1'b0);
    chk("ar_err", timeout_err_o, 1'b0);
    chk("ar_gnt", gnt_o, 4'b0);
    chk("ar_enb", switch_enb_o, 1'b0);

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
